program_loader: RTL and testbench

- Sequencer that boots and runs the pipelined core for bench and bring-up use.
- Accepts a stream of instruction words over a valid/ready interface and drives the core's instruction-memory write port (instr_in, instr_wr_addr, instr_wr_en).
- Holds the core in reset while loading, releases it, then watches for halt or a cycle-limit timeout.
- Sits beside the core; owns the core's reset and instruction write port.

---
 rtl/program_loader.sv | 159 +++++++++++++++
 tb/tb_program_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot sequencer for the pipelined core: streams instruction words into the
// core's instruction memory, holds the core in reset while flushing, releases
// it, then watches for halt or a run-cycle limit.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, load_len     begin a load of load_len words (clipped to SIZE)
//   max_cycles          run limit (0 = unlimited), sampled with start
//   s_data/s_valid/s_ready   instruction word stream (valid/ready)
//   instr_in/instr_wr_addr/instr_wr_en   core instruction-memory write port
//   core_reset          reset to the core (high except while running)
//   halt                core completion indication
//   busy/done/timeout   status; done and timeout are sticky
//   cycle_count         RUN cycles elapsed (saturating)
//   words_loaded        words accepted during the current load
//
// Latency: one cycle from an accepted word to its memory write strobe.
// Backpressure: s_ready is high only in LOAD; words are never dropped once
// accepted and s_data is ignored whenever s_valid is low.

module program_loader #(
    parameter  int WIDTH        = 32,
    parameter  int SIZE         = 64,
    parameter  int FLUSH_CYCLES = 4,
    parameter  int CNT_W        = 32,
    localparam int LOGSIZE      = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LOGSIZE:0]     load_len,
    input  logic [WIDTH-1:0]     s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [WIDTH-1:0]     instr_in,
    output logic [LOGSIZE+1:0]   instr_wr_addr,
    output logic                 instr_wr_en,
    output logic                 core_reset,
    input  logic                 halt,
    input  logic [CNT_W-1:0]     max_cycles,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [LOGSIZE:0]     words_loaded
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [LOGSIZE:0] SIZE_W  = (LOGSIZE+1)'(SIZE);
    localparam logic [3:0]       FLUSH_W = 4'(FLUSH_CYCLES);

    logic [2:0]           r_state;
    logic [LOGSIZE:0]     r_len;
    logic [CNT_W-1:0]     r_max;
    logic [LOGSIZE:0]     r_words;
    logic [CNT_W-1:0]     r_cnt;
    logic [3:0]           r_flush;
    logic                 r_done;
    logic                 r_timeout;
    logic                 r_wr_en;
    logic [LOGSIZE+1:0]   r_wr_addr;
    logic [WIDTH-1:0]     r_instr;

    logic                 w_s_ready;
    logic                 w_hs;
    logic [LOGSIZE:0]     w_len_clip;
    logic [LOGSIZE:0]     w_words_inc;
    logic [CNT_W-1:0]     w_cnt_inc;

    assign w_s_ready   = (r_state == S_LOAD);
    assign w_hs        = s_valid && w_s_ready;
    assign w_len_clip  = (load_len > SIZE_W) ? SIZE_W : load_len;
    assign w_words_inc = r_words + 1'b1;
    // Saturate rather than wrap so a very long run never looks short.
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_max     <= '0;
            r_words   <= '0;
            r_cnt     <= '0;
            r_flush   <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_instr   <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_flush <= '0;
                    if (start) begin
                        r_len     <= w_len_clip;
                        r_max     <= max_cycles;
                        r_words   <= '0;
                        r_cnt     <= '0;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_state   <= (w_len_clip != '0) ? S_LOAD : S_HOLD;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_instr   <= s_data;
                        r_wr_addr <= {r_words[LOGSIZE-1:0], 2'b00};
                        r_wr_en   <= 1'b1;
                        r_words   <= w_words_inc;
                        if (w_words_inc == r_len) begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // The first HOLD cycle carries the final memory write;
                    // the core then sees FLUSH_CYCLES more reset cycles after
                    // that write has landed.
                    if (r_flush == FLUSH_W) begin
                        r_state <= S_RUN;
                    end else begin
                        r_flush <= r_flush + 1'b1;
                    end
                end
                S_RUN: begin
                    r_cnt <= w_cnt_inc;
                    if (halt) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b0;
                    end else if ((r_max != '0) && (w_cnt_inc == r_max)) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_ready       = w_s_ready;
    assign core_reset    = (r_state != S_RUN);
    assign busy          = (r_state == S_LOAD) || (r_state == S_HOLD) || (r_state == S_RUN);
    assign done          = r_done;
    assign timeout       = r_timeout;
    assign cycle_count   = r_cnt;
    assign words_loaded  = r_words;
    assign instr_in      = r_instr;
    assign instr_wr_addr = r_wr_addr;
    assign instr_wr_en   = r_wr_en;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with default parameters
// (WIDTH=32, SIZE=64, FLUSH_CYCLES=4, CNT_W=32).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [6:0]  load_len;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] instr_in;
    logic [7:0]  instr_wr_addr;
    logic        instr_wr_en;
    logic        core_reset;
    logic        halt;
    logic [31:0] max_cycles;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [6:0]  words_loaded;

    program_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .load_len      (load_len),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .instr_in      (instr_in),
        .instr_wr_addr (instr_wr_addr),
        .instr_wr_en   (instr_wr_en),
        .core_reset    (core_reset),
        .halt          (halt),
        .max_cycles    (max_cycles),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .cycle_count   (cycle_count),
        .words_loaded  (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int wr_seen = 0;

    // Count write strobes on the falling edge, one per pulse.
    always @(negedge clk) begin
        if (instr_wr_en === 1'b1) wr_seen = wr_seen + 1;
    end

    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic        exp_wr;
        logic [7:0]  exp_addr;
        logic        exp_rdy;
        logic [6:0]  exp_words;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total = n_total + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run();
        int k;
        k = 0;
        while (core_reset !== 1'b0 && k < 30) begin
            step();
            k++;
        end
        chk("wait_run_core_reset", 64'(core_reset), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int w0;

        // Toggling-valid load of 4 words; expected outputs after each edge.
        tv[0] = '{1'b1, 32'h11111111, 1'b1, 8'd0,  1'b1, 7'd1};
        tv[1] = '{1'b0, 32'hDEADBEEF, 1'b0, 8'd0,  1'b1, 7'd1};
        tv[2] = '{1'b0, 32'hDEADBEEF, 1'b0, 8'd0,  1'b1, 7'd1};
        tv[3] = '{1'b1, 32'h22222222, 1'b1, 8'd4,  1'b1, 7'd2};
        tv[4] = '{1'b1, 32'h33333333, 1'b1, 8'd8,  1'b1, 7'd3};
        tv[5] = '{1'b0, 32'hDEADBEEF, 1'b0, 8'd0,  1'b1, 7'd3};
        tv[6] = '{1'b1, 32'h44444444, 1'b1, 8'd12, 1'b0, 7'd4};
        tv[7] = '{1'b1, 32'hCAFEF00D, 1'b0, 8'd0,  1'b0, 7'd4};

        reset = 1'b1; start = 1'b0; load_len = '0; s_data = '0; s_valid = 1'b0;
        halt = 1'b0; max_cycles = '0;
        #1;
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_wr_en", 64'(instr_wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cycle_count", 64'(cycle_count), 64'd0);
        chk("rst_words", 64'(words_loaded), 64'd0);
        chk("rst_addr", 64'(instr_wr_addr), 64'd0);
        step(); step();
        reset = 1'b0;
        step();

        // ---- load 3 words with s_valid held high, then halt in RUN cycle 10
        start = 1'b1; load_len = 7'd3; max_cycles = 32'd0;
        s_valid = 1'b1; s_data = 32'h00500093;
        w0 = wr_seen;
        step();
        start = 1'b0;
        chk("l3_s_ready_load", 64'(s_ready), 64'd1);
        step();
        chk("l3_wr0_en", 64'(instr_wr_en), 64'd1);
        chk("l3_wr0_addr", 64'(instr_wr_addr), 64'd0);
        chk("l3_wr0_data", 64'(instr_in), 64'h00500093);
        s_data = 32'h00108113;
        step();
        chk("l3_wr1_en", 64'(instr_wr_en), 64'd1);
        chk("l3_wr1_addr", 64'(instr_wr_addr), 64'd4);
        chk("l3_wr1_data", 64'(instr_in), 64'h00108113);
        s_data = 32'h00000073;
        step();
        chk("l3_wr2_en", 64'(instr_wr_en), 64'd1);
        chk("l3_wr2_addr", 64'(instr_wr_addr), 64'd8);
        chk("l3_wr2_data", 64'(instr_in), 64'h00000073);
        chk("l3_s_ready_after", 64'(s_ready), 64'd0);
        chk("l3_core_reset_e0", 64'(core_reset), 64'd1);
        s_valid = 1'b0;
        repeat (4) step();
        chk("l3_core_reset_e4", 64'(core_reset), 64'd1);
        chk("l3_writes", 64'(wr_seen - w0), 64'd3);
        step();
        chk("l3_core_reset_e5", 64'(core_reset), 64'd0);
        chk("l3_busy_run", 64'(busy), 64'd1);
        repeat (9) step();
        chk("h10_count_before", 64'(cycle_count), 64'd9);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("h10_done", 64'(done), 64'd1);
        chk("h10_timeout", 64'(timeout), 64'd0);
        chk("h10_count", 64'(cycle_count), 64'd10);
        chk("h10_core_reset", 64'(core_reset), 64'd1);
        chk("h10_busy", 64'(busy), 64'd0);
        step(); step();
        chk("h10_count_hold", 64'(cycle_count), 64'd10);
        chk("h10_done_hold", 64'(done), 64'd1);

        // ---- table-driven load of 4 words with gaps in s_valid
        start = 1'b1; load_len = 7'd4; max_cycles = 32'd0; s_valid = 1'b0;
        step();
        start = 1'b0;
        chk("tog_done_cleared", 64'(done), 64'd0);
        w0 = wr_seen;
        for (int i = 0; i < 8; i++) begin
            s_valid = tv[i].vld;
            s_data  = tv[i].dat;
            step();
            chk($sformatf("tog%0d_wr_en", i), 64'(instr_wr_en), 64'(tv[i].exp_wr));
            if (tv[i].exp_wr) begin
                chk($sformatf("tog%0d_addr", i), 64'(instr_wr_addr), 64'(tv[i].exp_addr));
                chk($sformatf("tog%0d_data", i), 64'(instr_in), 64'(tv[i].dat));
            end
            chk($sformatf("tog%0d_s_ready", i), 64'(s_ready), 64'(tv[i].exp_rdy));
            chk($sformatf("tog%0d_words", i), 64'(words_loaded), 64'(tv[i].exp_words));
        end
        s_valid = 1'b0;
        chk("tog_writes", 64'(wr_seen - w0), 64'd4);
        wait_run();
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("tog_done", 64'(done), 64'd1);

        // ---- load_len=0, max_cycles=20, no halt -> timeout
        start = 1'b1; load_len = 7'd0; max_cycles = 32'd20;
        w0 = wr_seen;
        step();
        start = 1'b0;
        chk("to_s_ready", 64'(s_ready), 64'd0);
        chk("to_busy", 64'(busy), 64'd1);
        chk("to_words", 64'(words_loaded), 64'd0);
        repeat (5) step();
        chk("to_core_reset_run", 64'(core_reset), 64'd0);
        repeat (19) step();
        chk("to_done_early", 64'(done), 64'd0);
        chk("to_count19", 64'(cycle_count), 64'd19);
        step();
        chk("to_done", 64'(done), 64'd1);
        chk("to_timeout", 64'(timeout), 64'd1);
        chk("to_count", 64'(cycle_count), 64'd20);
        chk("to_writes", 64'(wr_seen - w0), 64'd0);

        // ---- same, but halt in RUN cycle 20 -> halt wins
        start = 1'b1; load_len = 7'd0; max_cycles = 32'd20;
        step();
        start = 1'b0;
        chk("th_timeout_cleared", 64'(timeout), 64'd0);
        repeat (5) step();
        repeat (19) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("th_done", 64'(done), 64'd1);
        chk("th_timeout", 64'(timeout), 64'd0);
        chk("th_count", 64'(cycle_count), 64'd20);

        // ---- load_len=100 clipped to SIZE=64
        start = 1'b1; load_len = 7'd100; max_cycles = 32'd0; s_valid = 1'b1;
        step();
        start = 1'b0;
        w0 = wr_seen;
        for (int i = 0; i < 64; i++) begin
            s_data = 32'hA0000000 | 32'(i);
            step();
        end
        chk("big_wr_en", 64'(instr_wr_en), 64'd1);
        chk("big_addr", 64'(instr_wr_addr), 64'd252);
        chk("big_data", 64'(instr_in), 64'hA000003F);
        chk("big_s_ready", 64'(s_ready), 64'd0);
        chk("big_words", 64'(words_loaded), 64'd64);
        s_valid = 1'b0;
        step();
        chk("big_writes", 64'(wr_seen - w0), 64'd64);
        chk("big_hold_core_reset", 64'(core_reset), 64'd1);

        // ---- asynchronous reset in the middle of RUN
        repeat (10) step();
        chk("ar_core_reset_run", 64'(core_reset), 64'd0);
        chk("ar_count_run", 64'(cycle_count), 64'd6);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_core_reset", 64'(core_reset), 64'd1);
        chk("ar_s_ready", 64'(s_ready), 64'd0);
        chk("ar_wr_en", 64'(instr_wr_en), 64'd0);
        chk("ar_done", 64'(done), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_count", 64'(cycle_count), 64'd0);
        chk("ar_words", 64'(words_loaded), 64'd0);
        #2;
        reset = 1'b0;
        step();
        chk("ar_idle_busy", 64'(busy), 64'd0);
        chk("ar_idle_core_reset", 64'(core_reset), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
